// File: rtl/ysyx_23060061_wbu_pkg.sv
// Shared definitions for the write-back unit: default widths, FIFO depth,
// pending-write counter width, the buffered result entry layout and the x0 index.
// Optional forwarding is enabled by defining YSYX_23060061_WBU_FWD_EN.
package ysyx_23060061_wbu_pkg;

    localparam int WBU_ADDR_WIDTH = 5;
    localparam int WBU_DATA_WIDTH = 32;
    localparam int WBU_DEPTH      = 2;
    localparam int WBU_CNT_WIDTH  = 2;

    // Register index that is hardwired to zero; writes to it are dropped.
    localparam logic [WBU_ADDR_WIDTH-1:0] X0_IDX = '0;

    // One buffered result at the default widths.
    typedef struct packed {
        logic [WBU_ADDR_WIDTH-1:0] rd;
        logic [WBU_DATA_WIDTH-1:0] data;
    } wbu_entry_t;

endpackage

// File: rtl/ysyx_23060061_wbu_fifo.sv
// Result FIFO for the write-back unit: DEPTH entries of {rd, data}.
// Ports: push_i/push_rd_i/push_data_i write the tail, pop_i drops the head,
// head_rd_o/head_data_o show the head, full_o/count_o give occupancy; with
// YSYX_23060061_WBU_FWD_EN an age-ordered view (index 0 = oldest) is exported.
module ysyx_23060061_wbu_fifo #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push_i,
    input  logic [ADDR_WIDTH-1:0]                push_rd_i,
    input  logic [DATA_WIDTH-1:0]                push_data_i,
    input  logic                                 pop_i,
    output logic [ADDR_WIDTH-1:0]                head_rd_o,
    output logic [DATA_WIDTH-1:0]                head_data_o,
    output logic                                 full_o,
`ifdef YSYX_23060061_WBU_FWD_EN
    output logic [DEPTH-1:0]                     ord_vld_o,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0]     ord_rd_o,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0]     ord_data_o,
`endif
    output logic [$clog2(DEPTH):0]               count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
        else if (pop_i && !push_i) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= '{rd: push_rd_i, data: push_data_i};
    end

    assign head_rd_o   = mem_q[rd_ptr_q].rd;
    assign head_data_o = mem_q[rd_ptr_q].data;
    assign full_o      = (cnt_q == CNT_W'(DEPTH));
    assign count_o     = cnt_q;

`ifdef YSYX_23060061_WBU_FWD_EN
    always_comb begin
        ord_vld_o  = '0;
        ord_rd_o   = '0;
        ord_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ord_vld_o[k]  = (CNT_W'(k) < cnt_q);
            ord_rd_o[k]   = mem_q[rd_ptr_q + PTR_W'(k)].rd;
            ord_data_o[k] = mem_q[rd_ptr_q + PTR_W'(k)].data;
        end
    end
`endif

endmodule

// File: rtl/ysyx_23060061_wbu.sv
// Write-back unit: buffers EXU/LSU results and drains one per cycle into the
// register file write port; a per-register pending-write scoreboard drives busy1/2.
// Ports: in_* accept results, drain_en gates draining, issue_* track writers,
// raddr*/busy*/fwd_* serve IDU, rf_* drive the register file. Forwarding is
// built only when YSYX_23060061_WBU_FWD_EN is defined; otherwise fwd_* are 0.
module ysyx_23060061_wbu
    import ysyx_23060061_wbu_pkg::*;
#(
    parameter int ADDR_WIDTH = WBU_ADDR_WIDTH,
    parameter int DATA_WIDTH = WBU_DATA_WIDTH,
    parameter int DEPTH      = WBU_DEPTH,
    parameter int CNT_WIDTH  = WBU_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  drain_en,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  fwd_valid1,
    output logic                  fwd_valid2,
    output logic [DATA_WIDTH-1:0] fwd_data1,
    output logic [DATA_WIDTH-1:0] fwd_data2,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int                    NREG    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] X0      = ADDR_WIDTH'(X0_IDX);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

    logic                  push, pop, issue_fire;
    logic                  fifo_full;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [ADDR_WIDTH-1:0] head_rd;
    logic [DATA_WIDTH-1:0] head_data;
`ifdef YSYX_23060061_WBU_FWD_EN
    logic [DEPTH-1:0]                 ord_vld;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] ord_rd;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] ord_data;
`endif

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = (fifo_count != '0) && drain_en;

    ysyx_23060061_wbu_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_rd_i   (in_rd),
        .push_data_i (in_data),
        .pop_i       (pop),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .full_o      (fifo_full),
`ifdef YSYX_23060061_WBU_FWD_EN
        .ord_vld_o   (ord_vld),
        .ord_rd_o    (ord_rd),
        .ord_data_o  (ord_data),
`endif
        .count_o     (fifo_count)
    );

    // x0 results still drain (keeping order) but never reach the register file.
    assign rf_wen   = pop && (head_rd != X0);
    assign rf_waddr = head_rd;
    assign rf_wdata = head_data;

    // Pending-write scoreboard.
    logic [CNT_WIDTH-1:0] cnt_q [NREG];
    logic [CNT_WIDTH-1:0] cnt_d [NREG];

    assign issue_ready = (issue_rd == X0) || (cnt_q[issue_rd] != CNT_MAX);
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != X0);

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (issue_fire && issue_rd == ADDR_WIDTH'(r)) begin
                // A coinciding pop of the same register cancels the issue.
                if (!(pop && head_rd == ADDR_WIDTH'(r))) cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (pop && head_rd == ADDR_WIDTH'(r) && cnt_q[r] != '0) begin
                // A pop with nothing pending is a producer error; hold at 0.
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    assign busy1 = (raddr1 != X0) && (cnt_q[raddr1] != '0);
    assign busy2 = (raddr2 != X0) && (cnt_q[raddr2] != '0);

`ifdef YSYX_23060061_WBU_FWD_EN
    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_valid1 = 1'b0;
        fwd_valid2 = 1'b0;
        fwd_data1  = '0;
        fwd_data2  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ord_vld[k] && raddr1 != X0 && ord_rd[k] == raddr1) begin
                fwd_valid1 = 1'b1;
                fwd_data1  = ord_data[k];
            end
            if (ord_vld[k] && raddr2 != X0 && ord_rd[k] == raddr2) begin
                fwd_valid2 = 1'b1;
                fwd_data2  = ord_data[k];
            end
        end
    end
`else
    assign fwd_valid1 = 1'b0;
    assign fwd_valid2 = 1'b0;
    assign fwd_data1  = '0;
    assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060061_wbu.sv
// Bench for the write-back unit: directed scenarios with hand-computed literal
// checks, plus a queue/counter model compared against the DUT every cycle.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_ysyx_23060061_wbu;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 2;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_rd = '0;
    logic [DW-1:0] in_data = '0;
    logic          drain_en = 1'b0;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_rd = '0;
    logic          issue_ready;
    logic [AW-1:0] raddr1 = '0, raddr2 = '0;
    logic          busy1, busy2, fwd_valid1, fwd_valid2;
    logic [DW-1:0] fwd_data1, fwd_data2;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    ysyx_23060061_wbu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data), .drain_en(drain_en),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .raddr1(raddr1), .raddr2(raddr2), .busy1(busy1), .busy2(busy2),
        .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          rd;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   mcnt [32];
    bit   model_ok = 0;
    bit   m_pop, m_iss, m_psh;
    int   m_prd;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            for (int r = 0; r < 32; r++) mcnt[r] = 0;
            model_ok = 1;
        end else if (model_ok) begin
            m_pop = (q.size() > 0) && drain_en;
            m_prd = m_pop ? q[0].rd : 0;
            m_iss = issue_valid && (issue_rd != 0) && (mcnt[issue_rd] < CMAX);
            m_psh = in_valid && (q.size() < DEPTH);
            if (m_pop) void'(q.pop_front());
            if (m_psh) q.push_back('{rd: int'(in_rd), data: in_data});
            if (m_iss) mcnt[issue_rd]++;
            if (m_prd != 0 && mcnt[m_prd] > 0) mcnt[m_prd]--;
        end
    end

    function automatic bit m_busy(input int a);
        return (a != 0) && (mcnt[a] != 0);
    endfunction

    function automatic logic [32:0] m_fwd(input int a);
        logic [32:0] res = '0;
`ifdef YSYX_23060061_WBU_FWD_EN
        for (int i = 0; i < q.size(); i++)
            if (a != 0 && q[i].rd == a) res = {1'b1, q[i].data};
`endif
        return res;
    endfunction

    // Single compare process against the model.
    logic [32:0] f1, f2;
    bit          e_wen;
    always @(negedge clk) begin
        if (model_ok) begin
            e_wen = (q.size() > 0) && drain_en && (q[0].rd != 0);
            chk("m_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            chk("m_rf_wen", 32'(rf_wen), 32'(e_wen));
            if (e_wen) begin
                chk("m_rf_waddr", 32'(rf_waddr), 32'(q[0].rd));
                chk("m_rf_wdata", rf_wdata, q[0].data);
            end
            chk("m_busy1", 32'(busy1), 32'(m_busy(int'(raddr1))));
            chk("m_busy2", 32'(busy2), 32'(m_busy(int'(raddr2))));
            chk("m_issue_ready", 32'(issue_ready),
                32'((issue_rd == 0) || (mcnt[issue_rd] < CMAX)));
            f1 = m_fwd(int'(raddr1));
            f2 = m_fwd(int'(raddr2));
            chk("m_fwd_valid1", 32'(fwd_valid1), 32'(f1[32]));
            chk("m_fwd_valid2", 32'(fwd_valid2), 32'(f2[32]));
            chk("m_fwd_data1", fwd_data1, f1[31:0]);
            chk("m_fwd_data2", fwd_data2, f2[31:0]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        nxt(); nxt();
        rst = 1'b0;
        issue_rd = 5'd7;
        neg();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_rf_wen", 32'(rf_wen), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);
        chk("rst_fwd_valid1", 32'(fwd_valid1), 32'd0);

        // Single result to x5 with drain enabled, writer issued alongside.
        nxt();
        in_valid = 1; in_rd = 5; in_data = 32'hDEADBEEF; drain_en = 1;
        issue_valid = 1; issue_rd = 5; raddr1 = 5;
        nxt();
        in_valid = 0; issue_valid = 0;
        neg();
        chk("t1_rf_wen", 32'(rf_wen), 32'd1);
        chk("t1_rf_waddr", 32'(rf_waddr), 32'd5);
        chk("t1_rf_wdata", rf_wdata, 32'hDEADBEEF);
        chk("t1_busy_pending", 32'(busy1), 32'd1);
        nxt();
        neg();
        chk("t1_no_second_wen", 32'(rf_wen), 32'd0);
        chk("t1_busy_cleared", 32'(busy1), 32'd0);

        // x0 result drains silently.
        nxt();
        in_valid = 1; in_rd = 0; in_data = 32'h1234;
        nxt();
        in_valid = 0;
        neg();
        chk("t2_x0_wen", 32'(rf_wen), 32'd0);
        nxt();

        // Fill with drain disabled, then drain in order.
        drain_en = 0;
        in_valid = 1; in_rd = 1; in_data = 32'hA1;
        nxt();
        in_rd = 2; in_data = 32'hA2;
        nxt();
        in_rd = 3; in_data = 32'hA3;
        neg();
        chk("t3_full_in_ready", 32'(in_ready), 32'd0);
        nxt();
        in_valid = 0; drain_en = 1;
        neg();
        chk("t3_drain0_waddr", 32'(rf_waddr), 32'd1);
        chk("t3_drain0_wdata", rf_wdata, 32'hA1);
        nxt();
        neg();
        chk("t3_drain1_waddr", 32'(rf_waddr), 32'd2);
        chk("t3_drain1_in_ready", 32'(in_ready), 32'd1);
        nxt();
        neg();
        chk("t3_third_dropped", 32'(rf_wen), 32'd0);

        // Two pending writes to x7.
        nxt();
        drain_en = 0; raddr1 = 7;
        issue_valid = 1; issue_rd = 7;
        nxt(); nxt();
        issue_valid = 0;
        in_valid = 1; in_rd = 7; in_data = 32'h70;
        nxt();
        in_data = 32'h71;
        nxt();
        in_valid = 0;
        neg();
        chk("t4_busy_two", 32'(busy1), 32'd1);
        drain_en = 1;
        nxt();
        neg();
        chk("t4_busy_after_pop1", 32'(busy1), 32'd1);
        nxt();
        neg();
        chk("t4_busy_after_pop2", 32'(busy1), 32'd0);
        drain_en = 0;

        // Issue and pop of x7 in the same cycle leaves the count at 1.
        issue_valid = 1; issue_rd = 7;
        in_valid = 1; in_rd = 7; in_data = 32'h72;
        nxt();
        in_valid = 0; drain_en = 1;
        nxt();
        issue_valid = 0; drain_en = 0;
        neg();
        chk("t4_same_cycle_busy", 32'(busy1), 32'd1);
        in_valid = 1; in_rd = 7; in_data = 32'h73; drain_en = 1;
        nxt();
        in_valid = 0;
        nxt();
        neg();
        chk("t4_final_busy", 32'(busy1), 32'd0);

        // Counter saturation on x9.
        issue_valid = 1; issue_rd = 9; raddr2 = 9; drain_en = 0;
        nxt(); nxt(); nxt();
        neg();
        chk("t5_sat_issue_ready", 32'(issue_ready), 32'd0);
        nxt();
        issue_valid = 0;
        drain_en = 1; in_valid = 1; in_rd = 9; in_data = 32'h99;
        nxt(); nxt(); nxt();
        in_valid = 0;
        nxt();
        neg();
        chk("t5_unsat_issue_ready", 32'(issue_ready), 32'd1);
        chk("t5_unsat_busy2", 32'(busy2), 32'd0);

        // Two buffered x3 results: forwarding picks the younger one.
        drain_en = 0;
        issue_valid = 1; issue_rd = 3;
        in_valid = 1; in_rd = 3; in_data = 32'h11;
        nxt();
        in_data = 32'h22;
        nxt();
        issue_valid = 0; in_valid = 0; raddr2 = 3;
        neg();
        chk("t6_busy2", 32'(busy2), 32'd1);
`ifdef YSYX_23060061_WBU_FWD_EN
        chk("t6_fwd_valid2", 32'(fwd_valid2), 32'd1);
        chk("t6_fwd_data2", fwd_data2, 32'h22);
`else
        chk("t6_fwd_valid2", 32'(fwd_valid2), 32'd0);
        chk("t6_fwd_data2", fwd_data2, 32'h0);
`endif

        // Reset with two buffered entries discards them.
        rst = 1;
        nxt();
        rst = 0; drain_en = 1;
        neg();
        chk("t7_rst_wen", 32'(rf_wen), 32'd0);
        chk("t7_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t7_rst_busy2", 32'(busy2), 32'd0);
        nxt();
        neg();
        chk("t7_rst_wen_later", 32'(rf_wen), 32'd0);

        // Mixed traffic on a few registers, checked by the model only.
        for (int i = 0; i < 300; i++) begin
            nxt();
            in_valid    = 1'($urandom_range(0, 1));
            in_rd       = AW'($urandom_range(0, 6));
            in_data     = $urandom;
            drain_en    = ($urandom_range(0, 3) != 0);
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = AW'($urandom_range(0, 6));
            raddr1      = AW'($urandom_range(0, 6));
            raddr2      = AW'($urandom_range(0, 6));
        end
        nxt();
        in_valid = 0; issue_valid = 0;
        nxt(); nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
